data_mem_unit: RTL and testbench
================================

// Module: data_mem_unit
// PURPOSE
//  Data-memory responder at the far end of the EX/MEM load/store interface. Accepts one read or write
//  request per access (address, store data, FUNC3 width), stalls the pipeline via MEM_BUSYWAIT for a
//  fixed latency, then commits the store or returns the sign/zero-extended load value.
//  Byte-addressed, little-endian, single-ported, word-organised storage.
// PARAMETERS
//  ADDR_WIDTH  10  byte-address bits used; depth = 2**(ADDR_WIDTH-2) words; higher ADDRESS bits ignored
//  LATENCY     2   ACCESS-state cycles before commit (>=1)
// PORTS
//  CLK           in   1   clock, all state on rising edge
//  RESET         in   1   synchronous, active-low reset
//  MEM_READ_EN   in   1   load request (level, held by pipeline until MEM_BUSYWAIT low)
//  MEM_WRITE_EN  in   1   store request (level, same hold rule)
//  ADDRESS       in   32  byte address (ALU result)
//  WRITE_DATA    in   32  store data (forwarded rs2); low byte/half used for SB/SH
//  FUNC3         in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  READ_DATA     out  32  extended load result, registered
//  MEM_BUSYWAIT  out  1   stall request to pipeline
//  MISALIGNED    out  1   one-cycle flag: completed access was misaligned
// BEHAVIOUR
//  Reset (RESET=0 at edge): state IDLE, counter 0, READ_DATA 0, MISALIGNED 0; MEM_BUSYWAIT forced 0
//   while RESET=0. Storage array is NOT cleared. Reset mid-access aborts; uncommitted store is lost.
//  Valid request = MEM_READ_EN XOR MEM_WRITE_EN. Both high = ignored (no busywait, no access).
//  FSM:
//   IDLE:   MEM_BUSYWAIT = valid request (combinational). On valid: latch ADDRESS, WRITE_DATA, FUNC3,
//           op type; counter <= LATENCY-1; -> ACCESS.
//   ACCESS: MEM_BUSYWAIT=1. Counter decrements; at counter==0: commit store / capture load into
//           READ_DATA, set MISALIGNED; -> DONE. Uses latched values only; input changes ignored.
//   DONE:   MEM_BUSYWAIT=0 for exactly one cycle; MISALIGNED valid this cycle only; -> IDLE.
//  Busywait high for LATENCY+1 cycles per access; back-to-back requests: next one accepted in IDLE
//   the cycle after DONE (one cycle with busywait low between accesses).
//  Word index = addr[ADDR_WIDTH-1:2]; higher bits wrap silently.
//  Alignment: H needs addr[0]=0, W needs addr[1:0]=00. Misaligned: low bits forced to 0 (H: addr[0];
//   W: addr[1:0]), access proceeds aligned, MISALIGNED=1 in DONE.
//  Loads: B/BU select byte addr[1:0], H/HU select half addr[1]; B/H sign-extend, BU/HU zero-extend.
//   Undefined FUNC3 (011,110,111) on load: READ_DATA <= 0.
//  Stores: SB writes 1 byte lane, SH 2 lanes, SW 4; other lanes untouched. FUNC3 not in {000,001,010}
//   on store: no write, completes normally.
//  READ_DATA holds its value through stores and idle cycles; updated only on load commit.
// TESTING
//  SW 0xDEADBEEF @0x10 then LW @0x10, LATENCY=2 -> busywait high 3 cycles each, READ_DATA=0xDEADBEEF.
//  SB 0x80 @0x13 over word 0x11223344, LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080; LW @0x10 -> 0x80223344.
//  SH 0x8001 @0x22, LH @0x22 -> 0xFFFF8001; LHU -> 0x00008001; LH @0x23 -> same data, MISALIGNED=1.
//  Both READ_EN and WRITE_EN high @0x30 data 0x5 -> busywait stays 0; later LW @0x30 returns old value.
//  RESET low during ACCESS of SW 0x12345678 @0x40 -> busywait 0, LW @0x40 returns pre-store value.
//  Drop MEM_WRITE_EN mid-ACCESS -> store still commits, busywait timing unchanged; ADDR_WIDTH=10,
//   access @0x400 aliases to @0x000.

Source files
------------

// File: rtl/data_mem_unit.sv
// Data-memory responder for the EX/MEM load/store interface: one access per request, fixed-latency
// busywait, byte/half/word stores with lane enables and sign/zero-extended registered loads.
module data_mem_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ_EN,
  input  logic        MEM_WRITE_EN,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  input  logic [2:0]  FUNC3,
  output logic [31:0] READ_DATA,
  output logic        MEM_BUSYWAIT,
  output logic        MISALIGNED
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [CW-1:0]         r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_func3;
  logic                  r_isWrite;
  logic [31:0]           r_readData;
  logic                  r_misaligned;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_valid;
  logic                  w_commit;
  logic                  w_isHalf;
  logic                  w_isWord;
  logic                  w_misaligned;
  logic [ADDR_WIDTH-1:0] w_alignedAddr;
  logic [ADDR_WIDTH-3:0] w_index;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_loadData;
  logic [3:0]            w_laneEn;
  logic [31:0]           w_storeData;
  logic                  w_unusedAddr;

  // Address bits above ADDR_WIDTH deliberately wrap onto the implemented storage.
  assign w_unusedAddr = ^ADDRESS[31:ADDR_WIDTH];

  assign w_valid   = MEM_READ_EN ^ MEM_WRITE_EN;
  assign w_commit  = (r_state == S_ACCESS) && (r_count == '0);
  assign READ_DATA  = r_readData;
  assign MISALIGNED = r_misaligned;

  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    MEM_BUSYWAIT = 1'b0;
    case (r_state)
      S_IDLE: begin
        MEM_BUSYWAIT = w_valid;
        if (w_valid) w_nextState = S_ACCESS;
      end
      S_ACCESS: begin
        MEM_BUSYWAIT = 1'b1;
        if (r_count == '0) w_nextState = S_DONE;
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
    if (!RESET) MEM_BUSYWAIT = 1'b0;
  end

  // HU only exists as a load; a store with 101 is simply a no-write and never flags alignment.
  assign w_isHalf     = (r_func3 == 3'b001) || (!r_isWrite && r_func3 == 3'b101);
  assign w_isWord     = (r_func3 == 3'b010);
  assign w_misaligned = (w_isHalf && r_addr[0]) || (w_isWord && (r_addr[1:0] != 2'b00));

  always_comb begin
    w_alignedAddr = r_addr;
    if (w_isWord)      w_alignedAddr[1:0] = 2'b00;
    else if (w_isHalf) w_alignedAddr[0]   = 1'b0;
  end

  assign w_index = w_alignedAddr[ADDR_WIDTH-1:2];
  assign w_word  = r_mem[w_index];
  assign w_byte  = w_word[{w_alignedAddr[1:0], 3'b000} +: 8];
  assign w_half  = w_alignedAddr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_loadData = 32'h0;
    case (r_func3)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b010:  w_loadData = w_word;
      3'b100:  w_loadData = {24'h0, w_byte};
      3'b101:  w_loadData = {16'h0, w_half};
      default: w_loadData = 32'h0;
    endcase
  end

  // Store data is replicated across lanes so the lane enables alone pick the destination.
  always_comb begin
    w_laneEn    = 4'b0000;
    w_storeData = r_wdata;
    case (r_func3)
      3'b000: begin
        w_laneEn    = 4'b0001 << w_alignedAddr[1:0];
        w_storeData = {4{r_wdata[7:0]}};
      end
      3'b001: begin
        w_laneEn    = w_alignedAddr[1] ? 4'b1100 : 4'b0011;
        w_storeData = {2{r_wdata[15:0]}};
      end
      3'b010:  w_laneEn = 4'b1111;
      default: w_laneEn = 4'b0000;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET && w_commit && r_isWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (w_laneEn[i]) r_mem[w_index][8*i +: 8] <= w_storeData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_count      <= '0;
      r_readData   <= 32'h0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_addr    <= ADDRESS[ADDR_WIDTH-1:0];
            r_wdata   <= WRITE_DATA;
            r_func3   <= FUNC3;
            r_isWrite <= MEM_WRITE_EN;
            r_count   <= CW'(LATENCY - 1);
          end
        end
        S_ACCESS: begin
          if (r_count == '0) begin
            r_misaligned <= w_misaligned;
            if (!r_isWrite) r_readData <= w_loadData;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: hand-computed load/store vectors, busywait timing,
// alignment, reset abort, input-drop and address aliasing.
module tb_data_mem_unit;

  logic        CLK;
  logic        RESET;
  logic        MEM_READ_EN;
  logic        MEM_WRITE_EN;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [2:0]  FUNC3;
  logic [31:0] READ_DATA;
  logic        MEM_BUSYWAIT;
  logic        MISALIGNED;

  int total = 0;
  int bad   = 0;

  int          busy;
  logic        mis;
  logic [31:0] rdata;

  data_mem_unit #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .MEM_READ_EN(MEM_READ_EN),
    .MEM_WRITE_EN(MEM_WRITE_EN),
    .ADDRESS(ADDRESS),
    .WRITE_DATA(WRITE_DATA),
    .FUNC3(FUNC3),
    .READ_DATA(READ_DATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .MISALIGNED(MISALIGNED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one request and holds it while busywait is high; returns in IDLE after DONE.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [2:0] f3, input bit dropMid,
                               output int busyCycles, output logic misOut, output logic [31:0] rdOut);
    busyCycles   = 0;
    MEM_READ_EN  = rd;
    MEM_WRITE_EN = wr;
    ADDRESS      = addr;
    WRITE_DATA   = data;
    FUNC3        = f3;
    #1;
    while (MEM_BUSYWAIT === 1'b1 && busyCycles < 20) begin
      busyCycles++;
      @(posedge CLK); #1;
      if (dropMid) begin
        MEM_READ_EN  = 1'b0;
        MEM_WRITE_EN = 1'b0;
        ADDRESS      = 32'hFFFF_FFFF;
        WRITE_DATA   = 32'h0;
        FUNC3        = 3'b111;
      end
    end
    if (busyCycles >= 20) checkOutput("busywait_timeout", 32'(busyCycles), 32'd3);
    misOut       = MISALIGNED;
    rdOut        = READ_DATA;
    MEM_READ_EN  = 1'b0;
    MEM_WRITE_EN = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    RESET        = 1'b0;
    MEM_READ_EN  = 1'b1;
    MEM_WRITE_EN = 1'b0;
    ADDRESS      = 32'h0;
    WRITE_DATA   = 32'h0;
    FUNC3        = 3'b010;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_busywait", 32'(MEM_BUSYWAIT), 32'd0);
    checkOutput("reset_read_data", READ_DATA, 32'h0);
    checkOutput("reset_misaligned", 32'(MISALIGNED), 32'd0);
    MEM_READ_EN = 1'b0;
    RESET       = 1'b1;
    @(posedge CLK); #1;

    applyStimulus(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0, busy, mis, rdata);
    checkOutput("sw_busy_cycles", 32'(busy), 32'd3);
    checkOutput("sw_misaligned", 32'(mis), 32'd0);
    applyStimulus(1, 0, 32'h10, 32'h0, 3'b010, 0, busy, mis, rdata);
    checkOutput("lw_busy_cycles", 32'(busy), 32'd3);
    checkOutput("lw_deadbeef", rdata, 32'hDEADBEEF);

    applyStimulus(0, 1, 32'h10, 32'h11223344, 3'b010, 0, busy, mis, rdata);
    applyStimulus(0, 1, 32'h13, 32'hAAAAAA80, 3'b000, 0, busy, mis, rdata);
    checkOutput("read_data_held_over_store", rdata, 32'hDEADBEEF);
    applyStimulus(1, 0, 32'h13, 32'h0, 3'b000, 0, busy, mis, rdata);
    checkOutput("lb_0x13", rdata, 32'hFFFFFF80);
    applyStimulus(1, 0, 32'h13, 32'h0, 3'b100, 0, busy, mis, rdata);
    checkOutput("lbu_0x13", rdata, 32'h00000080);
    applyStimulus(1, 0, 32'h10, 32'h0, 3'b010, 0, busy, mis, rdata);
    checkOutput("lw_after_sb", rdata, 32'h80223344);
    applyStimulus(1, 0, 32'h12, 32'h0, 3'b000, 0, busy, mis, rdata);
    checkOutput("lb_0x12_positive", rdata, 32'h00000022);
    applyStimulus(1, 0, 32'h12, 32'h0, 3'b001, 0, busy, mis, rdata);
    checkOutput("lh_0x12_upper_half", rdata, 32'hFFFF8022);
    applyStimulus(1, 0, 32'h12, 32'h0, 3'b010, 0, busy, mis, rdata);
    checkOutput("lw_misaligned_data", rdata, 32'h80223344);
    checkOutput("lw_misaligned_flag", 32'(mis), 32'd1);

    applyStimulus(0, 1, 32'h20, 32'h0, 3'b010, 0, busy, mis, rdata);
    applyStimulus(0, 1, 32'h22, 32'h12348001, 3'b001, 0, busy, mis, rdata);
    applyStimulus(1, 0, 32'h22, 32'h0, 3'b001, 0, busy, mis, rdata);
    checkOutput("lh_0x22", rdata, 32'hFFFF8001);
    checkOutput("lh_0x22_aligned_flag", 32'(mis), 32'd0);
    applyStimulus(1, 0, 32'h22, 32'h0, 3'b101, 0, busy, mis, rdata);
    checkOutput("lhu_0x22", rdata, 32'h00008001);
    applyStimulus(1, 0, 32'h23, 32'h0, 3'b001, 0, busy, mis, rdata);
    checkOutput("lh_0x23_data", rdata, 32'hFFFF8001);
    checkOutput("lh_0x23_misaligned", 32'(mis), 32'd1);
    checkOutput("misaligned_one_cycle", 32'(MISALIGNED), 32'd0);
    applyStimulus(1, 0, 32'h20, 32'h0, 3'b010, 0, busy, mis, rdata);
    checkOutput("lw_after_sh", rdata, 32'h80010000);

    applyStimulus(1, 0, 32'h20, 32'h0, 3'b011, 0, busy, mis, rdata);
    checkOutput("load_undefined_func3", rdata, 32'h0);

    applyStimulus(0, 1, 32'h30, 32'hCAFEF00D, 3'b010, 0, busy, mis, rdata);
    MEM_READ_EN  = 1'b1;
    MEM_WRITE_EN = 1'b1;
    ADDRESS      = 32'h30;
    WRITE_DATA   = 32'h5;
    FUNC3        = 3'b010;
    #1;
    checkOutput("both_en_busy_now", 32'(MEM_BUSYWAIT), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("both_en_busy_later", 32'(MEM_BUSYWAIT), 32'd0);
    MEM_READ_EN  = 1'b0;
    MEM_WRITE_EN = 1'b0;
    @(posedge CLK); #1;
    applyStimulus(1, 0, 32'h30, 32'h0, 3'b010, 0, busy, mis, rdata);
    checkOutput("both_en_no_write", rdata, 32'hCAFEF00D);

    applyStimulus(0, 1, 32'h40, 32'hA5A5A5A5, 3'b010, 0, busy, mis, rdata);
    MEM_WRITE_EN = 1'b1;
    ADDRESS      = 32'h40;
    WRITE_DATA   = 32'h12345678;
    FUNC3        = 3'b010;
    @(posedge CLK); #1;
    RESET        = 1'b0;
    MEM_WRITE_EN = 1'b0;
    #1;
    checkOutput("reset_abort_busywait", 32'(MEM_BUSYWAIT), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_abort_read_data", READ_DATA, 32'h0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    applyStimulus(1, 0, 32'h40, 32'h0, 3'b010, 0, busy, mis, rdata);
    checkOutput("reset_abort_store_lost", rdata, 32'hA5A5A5A5);

    applyStimulus(0, 1, 32'h50, 32'h0BADF00D, 3'b010, 1, busy, mis, rdata);
    checkOutput("drop_mid_busy_cycles", 32'(busy), 32'd3);
    applyStimulus(1, 0, 32'h50, 32'h0, 3'b010, 0, busy, mis, rdata);
    checkOutput("drop_mid_store_commits", rdata, 32'h0BADF00D);

    applyStimulus(0, 1, 32'h60, 32'h0, 3'b010, 0, busy, mis, rdata);
    applyStimulus(0, 1, 32'h60, 32'hFFFFFFFF, 3'b100, 0, busy, mis, rdata);
    checkOutput("store_bad_func3_busy", 32'(busy), 32'd3);
    applyStimulus(1, 0, 32'h60, 32'h0, 3'b010, 0, busy, mis, rdata);
    checkOutput("store_bad_func3_no_write", rdata, 32'h0);

    applyStimulus(0, 1, 32'h400, 32'h600DCAFE, 3'b010, 0, busy, mis, rdata);
    applyStimulus(1, 0, 32'h000, 32'h0, 3'b010, 0, busy, mis, rdata);
    checkOutput("alias_0x400_to_0x000", rdata, 32'h600DCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
